inst_fetch: RTL
===============

Name: inst_fetch

Overview:
- Instruction-fetch front end that drives the instruction-port side of the data RAM (pc_ce, pc_addr) and consumes its synchronous instruction ROM output (inst_o).
- Generates the sequential PC and absorbs the ROM's one-cycle read latency.
- Handles decode stalls with a one-entry hold buffer, and branch/jump redirects with a kill of the in-flight fetch.
- Presents inst/pc/valid to the decode stage.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INST, 32'h0000_0013, RV32I addi x0,x0,0; used only with the optional feature

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
stall_i  input  1  decode cannot accept an instruction this cycle
flush_i  input  1  redirect request; discard everything in flight
flush_pc_i  input  32  redirect target; bits [1:0] ignored (forced 0)
pc_ce_o  output  1  instruction ROM read enable (to pc_ce)
pc_addr_o  output  32  instruction ROM byte address (to pc_addr; ROM uses [11:2])
inst_i  input  32  ROM read data (from inst_o); valid the cycle after the issuing edge
inst_o  output  32  instruction to decode
inst_pc_o  output  32  byte address of inst_o
inst_valid_o  output  1  inst_o/inst_pc_o hold a live instruction

Behaviour:
- State registers:
  - pc_q: next sequential fetch address.
  - req_pend_q, req_pc_q: a fetch was issued at the last edge.
  - hold_v_q, hold_inst_q, hold_pc_q: one-entry hold buffer.
- Reset (rst=1 at an edge): pc_q=RESET_PC, req_pend_q=0, hold_v_q=0, req_pc_q=0, hold_pc_q=0, hold_inst_q=0. While rst=1: pc_ce_o=0, inst_valid_o=0, inst_pc_o=0.
- Issue (combinational):
  - pc_ce_o = !rst && !stall_i.
  - pc_addr_o = flush_i ? {flush_pc_i[31:2],2'b00} : pc_q.
  - On an edge with pc_ce_o=1: req_pend_q<=1, req_pc_q<=pc_addr_o, pc_q<=pc_addr_o+4 (32-bit wrap: 32'hFFFF_FFFC -> 0).
  - Otherwise req_pend_q<=0.
- Response valid: resp_v = req_pend_q && !flush_i. Latency from issue edge to inst_valid_o is 1 cycle.
- Output mux (combinational):
  - inst_valid_o = !flush_i && (hold_v_q || resp_v).
  - inst_o = hold_v_q ? hold_inst_q : inst_i.
  - inst_pc_o = hold_v_q ? hold_pc_q : req_pc_q.
- Handshake: decode consumes when inst_valid_o && !stall_i. No back-pressure otherwise; at most one fetch outstanding.
- Hold capture: at an edge with stall_i=1, resp_v=1, hold_v_q=0: hold_v_q<=1, hold_inst_q<=inst_i, hold_pc_q<=req_pc_q.
- Hold release: at an edge with stall_i=0 and hold_v_q=1, hold_v_q<=0. A new fetch issues in the same cycle.
- Invariant: response and hold are never both valid, because issue requires !stall_i. Bench asserts !(hold_v_q && req_pend_q).
- Stall with nothing in flight: outputs stay invalid and pc_q holds.
- Flush:
  - Same cycle: inst_valid_o=0, hold_v_q<=0, in-flight response discarded.
  - If !stall_i: the target issues immediately and its instruction is valid next cycle.
  - If stall_i=1: pc_q<=target, req_pend_q<=0; the target issues on the first non-stall cycle.
- Flush has priority over hold capture. Consecutive flushes: last target wins.
- Reset mid-operation discards hold and in-flight fetch; no valid output appears for the pre-reset fetch.

Optional Feature:
- Macro: INST_FETCH_NOP_FILL_EN.
- Defined: when inst_valid_o=0, inst_o=NOP_INST and inst_pc_o=0, so a decode stage without a valid input sees a bubble.
- Undefined: inst_o/inst_pc_o follow the output mux regardless of valid; contents when invalid are don't-care.

Test Plan:
- Reset release, RESET_PC=0, ROM word n = 32'h1000_0000+n, no stall: pc_addr_o sequence 0,4,8,C. inst_valid_o rises 1 cycle after rst falls; inst_o/inst_pc_o = 10000000/0, 10000001/4, 10000002/8.
- 3-cycle stall_i asserted the cycle inst_pc_o=8: pc_ce_o=0 for 3 cycles. inst_o holds 10000002/8 throughout. After release, next valid instruction is 10000003/C with no duplicate and no gap beyond 1 cycle.
- flush_i one cycle with flush_pc_i=32'h0000_0102 while the fetch of 0x10 is in flight: inst_valid_o=0 that cycle, 0x10 never presented, pc_addr_o=0x100. Next cycle valid 10000040/0x100, then 0x104.
- flush_i and stall_i both high for 1 cycle with a held instruction, target 0x200: hold discarded, pc_ce_o=0. Next cycle pc_addr_o=0x200; valid instruction at 0x200 one cycle later.
- Wrap: flush to 32'hFFFF_FFFC: presented pc FFFF_FFFC then 0000_0000.
- INST_FETCH_NOP_FILL_EN defined: during reset, flush and stall-empty cycles inst_o=32'h0000_0013 and inst_pc_o=0. Undefined: the same sequence produces identical valid-cycle outputs.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction-fetch front end: sequential PC, one-cycle ROM latency, one-entry stall hold, flush redirect.
// Optional macro INST_FETCH_NOP_FILL_EN: drive NOP_INST / pc 0 on the decode side whenever no instruction is valid.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic        pc_ce_o,
    output logic [31:0] pc_addr_o,
    input  logic [31:0] inst_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        inst_valid_o
);

    logic [31:0] pc_q, pc_d;
    logic        req_pend_q, req_pend_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        hold_v_q, hold_v_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic [31:0] hold_pc_q, hold_pc_d;

    logic [31:0] flush_tgt;
    logic        resp_v;
    logic        valid;
    logic [31:0] mux_inst;
    logic [31:0] mux_pc;

`ifdef INST_FETCH_NOP_FILL_EN
    logic [1:0]  unused_bits;
    assign unused_bits = flush_pc_i[1:0];
`else
    logic        unused_bits;
    assign unused_bits = ^{flush_pc_i[1:0], NOP_INST};
`endif

    always_comb begin
        flush_tgt = {flush_pc_i[31:2], 2'b00};
        pc_ce_o   = !rst && !stall_i;
        pc_addr_o = flush_i ? flush_tgt : pc_q;
        resp_v    = req_pend_q && !flush_i;
        valid     = !rst && !flush_i && (hold_v_q || resp_v);
        mux_inst  = hold_v_q ? hold_inst_q : inst_i;
        mux_pc    = hold_v_q ? hold_pc_q : req_pc_q;
    end

    always_comb begin
        inst_valid_o = valid;
`ifdef INST_FETCH_NOP_FILL_EN
        inst_o    = valid ? mux_inst : NOP_INST;
        inst_pc_o = valid ? mux_pc : 32'h0000_0000;
`else
        inst_o    = mux_inst;
        inst_pc_o = rst ? 32'h0000_0000 : mux_pc;
`endif
    end

    always_comb begin
        pc_d        = pc_q;
        req_pend_d  = 1'b0;
        req_pc_d    = req_pc_q;
        hold_v_d    = hold_v_q;
        hold_inst_d = hold_inst_q;
        hold_pc_d   = hold_pc_q;

        if (pc_ce_o) begin
            req_pend_d = 1'b1;
            req_pc_d   = pc_addr_o;
            pc_d       = pc_addr_o + 32'd4;
        end else if (flush_i) begin
            // Redirect while stalled: park the target until decode frees up.
            pc_d = flush_tgt;
        end

        if (flush_i) begin
            hold_v_d = 1'b0;
        end else if (stall_i && resp_v && !hold_v_q) begin
            hold_v_d    = 1'b1;
            hold_inst_d = inst_i;
            hold_pc_d   = req_pc_q;
        end else if (!stall_i && hold_v_q) begin
            hold_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            req_pend_q  <= 1'b0;
            req_pc_q    <= 32'h0000_0000;
            hold_v_q    <= 1'b0;
            hold_inst_q <= 32'h0000_0000;
            hold_pc_q   <= 32'h0000_0000;
        end else begin
            pc_q        <= pc_d;
            req_pend_q  <= req_pend_d;
            req_pc_q    <= req_pc_d;
            hold_v_q    <= hold_v_d;
            hold_inst_q <= hold_inst_d;
            hold_pc_q   <= hold_pc_d;
        end
    end

endmodule
